// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame format, defaults and receiver state encoding
package uart_pkg;

    // Default frame geometry: 8 data bits, LSB first, 8 ticks per bit.
    localparam int UART_DATA_BITS   = 8;
    localparam int UART_OVERSAMPLE  = 8;
    localparam int UART_SYNC_STAGES = 2;

    // Line levels of the 8N1 frame; the transmitter drives the same levels.
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

    // Receiver states. BREAK parks the receiver while the line is held low
    // after a framing error so a break is not decoded as a run of 0x00 bytes.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - multi-flop synchronizer for an asynchronous single-bit input
module sync_2ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the raw input through the chain; reset to the inactive level.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff <= STAGES'({ff, d});
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled 8N1 UART receiver producing a byte and one-cycle strobes
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = UART_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_8x,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Start bit is checked half a bit after the edge; every later sample
    // is a full bit period after the previous one, landing mid-bit.
    localparam logic [TW-1:0] TCNT_START_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TCNT_LAST      = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BCNT_LAST      = BW'(DATA_BITS - 1);

    uart_rx_state_e       state;
    uart_rx_state_e       state_next;

    logic                 rxs;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] sr;

    logic                 start_mid;
    logic                 bit_mid;
    logic                 last_bit;

    logic                 tcnt_clr;
    logic                 tcnt_inc;
    logic                 bcnt_clr;
    logic                 shift_en;
    logic                 frame_ok;
    logic                 frame_bad;

    sync_2ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (UART_IDLE_LEVEL)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    assign start_mid = (tcnt == TCNT_START_MID);
    assign bit_mid   = (tcnt == TCNT_LAST);
    assign last_bit  = (bcnt == BCNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; the FSM only moves on oversampling ticks.
    always_comb begin
        state_next = state;
        if (tick_8x) begin
            case (state)
                IDLE: begin
                    if (rxs == UART_START_LEVEL) begin
                        state_next = START;
                    end
                end
                START: begin
                    if (start_mid) begin
                        state_next = (rxs == UART_START_LEVEL) ? DATA : IDLE;
                    end
                end
                DATA: begin
                    if (bit_mid && last_bit) begin
                        state_next = STOP;
                    end
                end
                STOP: begin
                    // Leaving mid stop bit lets a back-to-back start edge be seen.
                    if (bit_mid) begin
                        state_next = (rxs == UART_STOP_LEVEL) ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    if (rxs == UART_IDLE_LEVEL) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath controls and busy flag decoded from the current state.
    always_comb begin
        tcnt_clr  = 1'b0;
        tcnt_inc  = 1'b0;
        bcnt_clr  = 1'b0;
        shift_en  = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                tcnt_clr = 1'b1;
                bcnt_clr = 1'b1;
            end
            START: begin
                if (tick_8x) begin
                    if (start_mid) begin
                        tcnt_clr = 1'b1;
                        bcnt_clr = 1'b1;
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick_8x) begin
                    if (bit_mid) begin
                        tcnt_clr = 1'b1;
                        shift_en = 1'b1;
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick_8x) begin
                    if (bit_mid) begin
                        tcnt_clr  = 1'b1;
                        frame_ok  = (rxs == UART_STOP_LEVEL);
                        frame_bad = (rxs != UART_STOP_LEVEL);
                    end else begin
                        tcnt_inc = 1'b1;
                    end
                end
            end
            BREAK: begin
                tcnt_clr = 1'b1;
            end
            default: begin
                tcnt_clr = 1'b1;
                bcnt_clr = 1'b1;
            end
        endcase
    end

    // Counters, LSB-first shift register and registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt      <= '0;
            bcnt      <= '0;
            sr        <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= frame_ok;
            frame_err <= frame_bad;

            if (frame_ok) begin
                rx_data <= sr;
            end

            if (tcnt_clr) begin
                tcnt <= '0;
            end else if (tcnt_inc) begin
                tcnt <= tcnt + 1'b1;
            end

            if (bcnt_clr) begin
                bcnt <= '0;
            end else if (shift_en) begin
                bcnt <= bcnt + 1'b1;
            end

            if (shift_en) begin
                sr <= {rxs, sr[DATA_BITS-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with directed and random 8N1 frames
module tb_uart_rx;

    localparam int DB = 8;
    localparam int OS = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick_8x;
    logic          rx;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int tick_div = 4;
    int tick_cnt = 0;

    typedef struct {
        bit            is_err;
        logic [DB-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DB-1:0] exp_hold = '0;

    uart_rx #(
        .DATA_BITS   (DB),
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_8x   (tick_8x),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bit_clks();
        return OS * tick_div;
    endfunction

    // One tick every tick_div clocks; tick_div = 1 holds the enable high.
    initial begin
        tick_8x = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_cnt >= tick_div - 1) begin
                tick_cnt = 0;
                tick_8x  = 1'b1;
            end else begin
                tick_cnt++;
                tick_8x = 1'b0;
            end
        end
    end

    task automatic idle_line(input int n);
        rx = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame; abort_clks >= 0 cuts it short. With corrupt set,
    // data bits carry their true value only within about one tick of mid-bit.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit,
                              input bit corrupt, input int abort_clks);
        logic [DB+1:0] f;
        logic          v;
        int            n;
        int            bp;
        exp_t          e;
        f  = {stop_bit, d, 1'b0};
        bp = bit_clks();
        n  = 0;
        if (abort_clks < 0) begin
            e.is_err = !stop_bit;
            e.data   = d;
            exp_q.push_back(e);
        end
        for (int idx = 0; idx < DB + 2; idx++) begin
            for (int c = 0; c < bp; c++) begin
                if (abort_clks >= 0 && n == abort_clks) return;
                v = f[idx];
                if (corrupt && idx >= 1 && idx <= DB &&
                    (c < 3 * tick_div || c > 5 * tick_div + 4)) begin
                    v = ~v;
                end
                rx = v;
                @(posedge clk);
                #1;
                n++;
            end
        end
        rx = 1'b1;
    endtask

    // Monitor: every strobe must match the head of the expected queue, and
    // rx_data must always equal the last good byte (zero after reset).
    initial begin
        forever begin
            @(negedge clk);
            if (rst) exp_hold = '0;
            if (rx_valid || frame_err) begin
                chk("strobe_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got valid=%0b err=%0b data=0x%0h, expected no strobe at %0t",
                             rx_valid, frame_err, rx_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("strobe_kind_err", {31'd0, frame_err}, {31'd0, mon_e.is_err});
                    if (!mon_e.is_err) exp_hold = mon_e.data;
                end
            end
            if (!rst) chk("rx_data", {24'd0, rx_data}, {24'd0, exp_hold});
        end
    end

    initial begin
        bit            seen_busy;
        logic [DB-1:0] d;
        logic          s;
        int            bp;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle_line(20);

        // Single frame.
        tick_div = 4;
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        chk("a5_busy_done", {31'd0, busy}, 32'd0);
        chk("a5_drained", exp_q.size(), 32'd0);

        // Back-to-back, no idle between stop bit and next start bit.
        send_frame(8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        chk("b2b_busy_done", {31'd0, busy}, 32'd0);
        chk("b2b_drained", exp_q.size(), 32'd0);

        // Two-tick low glitch: start validation rejects it.
        idle_line(bit_clks());
        seen_busy = 1'b0;
        rx = 1'b0;
        repeat (2 * tick_div) begin
            @(posedge clk);
            #1;
            if (busy) seen_busy = 1'b1;
        end
        rx = 1'b1;
        repeat (6 * tick_div) begin
            @(posedge clk);
            #1;
            if (busy) seen_busy = 1'b1;
        end
        chk("glitch_busy_seen", {31'd0, seen_busy}, 32'd1);
        chk("glitch_busy_done", {31'd0, busy}, 32'd0);

        // Framing error followed by a held-low break, then a good frame.
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        rx = 1'b0;
        repeat (3 * bit_clks()) begin
            @(posedge clk);
            #1;
        end
        chk("break_busy_held", {31'd0, busy}, 32'd1);
        idle_line(bit_clks());
        chk("break_busy_released", {31'd0, busy}, 32'd0);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        chk("break_drained", exp_q.size(), 32'd0);

        // Reset in the middle of data bit 4 of 0x5A.
        bp = bit_clks();
        send_frame(8'h5A, 1'b1, 1'b0, 5 * bp + bp / 2);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle_line(bit_clks());
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        chk("midrst_drained", exp_q.size(), 32'd0);

        // Slow rate with bits valid only near mid-bit.
        tick_div = 12;
        idle_line(bit_clks());
        send_frame(8'h55, 1'b1, 1'b1, -1);
        chk("slow_busy_done", {31'd0, busy}, 32'd0);
        chk("slow_drained", exp_q.size(), 32'd0);

        // Random frames at random tick rates, including continuous ticks.
        for (int i = 0; i < 24; i++) begin
            tick_div = $urandom_range(1, 4);
            d = DB'($urandom);
            s = ($urandom_range(0, 5) != 0);
            send_frame(d, s, 1'b0, -1);
            if (!s) idle_line(bit_clks() * (1 + $urandom_range(0, 1)));
            else    idle_line($urandom_range(0, bit_clks()));
        end

        idle_line(2 * bit_clks());
        chk("final_busy", {31'd0, busy}, 32'd0);
        chk("final_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
